traffic_light_monitor: RTL

Passive observer sitting on the far side of the intersection controller's output bus. It consumes the row and column light codes and the two-digit seven-segment display words. From them it recovers each direction's phase and displayed countdown value, measures phase durations, and raises sticky safety and protocol errors. It drives nothing back into the controller and is used both on the board (error LEDs) and as a bench checker.

---
 rtl/traffic_light_monitor_pkg.sv | 63 ++++++
 rtl/traffic_light_monitor_if.sv | 23 ++
 rtl/traffic_light_monitor_seven_segment_to_bcd.sv | 31 +++
 rtl/traffic_light_monitor.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/traffic_light_monitor_pkg.sv
// Shared definitions for the traffic light monitor: phase encodings, segment
// patterns, error bit positions and light code helpers.
package traffic_light_monitor_pkg;

  typedef enum logic [1:0] {
    PHASE_UNKNOWN = 2'd0,
    PHASE_GREEN   = 2'd1,
    PHASE_YELLOW  = 2'd2,
    PHASE_RED     = 2'd3
  } phase_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int ERR_CONFLICT  = 0;
  localparam int ERR_ROW_CODE  = 1;
  localparam int ERR_COL_CODE  = 2;
  localparam int ERR_SEQUENCE  = 3;
  localparam int ERR_SEGMENT   = 4;
  localparam int ERR_COUNTDOWN = 5;

  localparam int LIGHT_GREEN  = 0;
  localparam int LIGHT_YELLOW = 1;
  localparam int LIGHT_RED    = 2;

  localparam logic [2:0] LIGHTS_GREEN  = 3'(1 << LIGHT_GREEN);
  localparam logic [2:0] LIGHTS_YELLOW = 3'(1 << LIGHT_YELLOW);
  localparam logic [2:0] LIGHTS_RED    = 3'(1 << LIGHT_RED);

  // Any code that is not exactly one lamp maps to UNKNOWN.
  function automatic phase_t light_to_phase(input logic [2:0] lights);
    phase_t phase;
    phase = PHASE_UNKNOWN;
    if (lights == LIGHTS_GREEN)       phase = PHASE_GREEN;
    else if (lights == LIGHTS_YELLOW) phase = PHASE_YELLOW;
    else if (lights == LIGHTS_RED)    phase = PHASE_RED;
    return phase;
  endfunction

  // Moves into UNKNOWN are reported through the light code flags instead.
  function automatic logic legal_transition(input phase_t from, input phase_t to);
    logic ok;
    ok = (from == to) || (from == PHASE_UNKNOWN) || (to == PHASE_UNKNOWN) ||
         (from == PHASE_GREEN  && to == PHASE_YELLOW) ||
         (from == PHASE_YELLOW && to == PHASE_RED) ||
         (from == PHASE_RED    && to == PHASE_GREEN);
    return ok;
  endfunction

  function automatic logic is_moving(input phase_t phase);
    return (phase == PHASE_GREEN) || (phase == PHASE_YELLOW);
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Controller output bus as seen by the monitor: light codes and display words.
interface traffic_light_monitor_if;

  logic [2:0]  row_traffic_lights;
  logic [2:0]  column_traffic_lights;
  logic [13:0] row_display;
  logic [13:0] column_display;

  modport master (
    output row_traffic_lights,
    output column_traffic_lights,
    output row_display,
    output column_display
  );

  modport slave (
    input row_traffic_lights,
    input column_traffic_lights,
    input row_display,
    input column_display
  );

endinterface

// File: rtl/traffic_light_monitor_seven_segment_to_bcd.sv
// Combinational seven-segment (gfedcba) to decimal digit decoder; a blank
// pattern is accepted only for the tens position.
module seven_segment_to_bcd
  import traffic_light_monitor_pkg::*;
(
  input  logic [6:0] pattern,
  input  logic       is_tens,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: valid = is_tens;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive two-stage observer of the intersection controller outputs: tracks
// each direction's phase and countdown and latches sticky safety errors.
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  traffic_light_monitor_if.slave bus,
  output logic [1:0]             row_phase,
  output logic [1:0]             column_phase,
  output logic [6:0]             row_value,
  output logic [6:0]             column_value,
  output logic [7:0]             row_phase_cycles,
  output logic [7:0]             column_phase_cycles,
  output logic [5:0]             error
);

  // Index 0 is the row direction, index 1 the column direction.
  logic [1:0][2:0]  lights_s1;
  logic [1:0][13:0] display_s1;
  logic             sample_valid;

  phase_t [1:0]     phase_q;
  phase_t [1:0]     phase_d;
  phase_t [1:0]     seen_phase;
  logic [1:0][7:0]  count_q;
  logic [1:0][7:0]  count_d;
  logic [1:0][7:0]  cycles_q;
  logic [1:0][7:0]  cycles_d;
  logic [1:0][6:0]  value_q;
  logic [1:0][6:0]  value_d;
  logic [1:0][6:0]  decoded;
  logic [1:0][3:0]  tens_digit;
  logic [1:0][3:0]  ones_digit;
  logic [1:0]       tens_ok;
  logic [1:0]       ones_ok;
  logic [1:0]       digit_bad;
  logic [1:0]       digit_err_q;
  logic [1:0]       digit_err_d;
  logic [1:0]       changed;
  logic [5:0]       error_q;
  logic [5:0]       flags;

  always_ff @(posedge clock) begin
    if (reset) begin
      lights_s1    <= '0;
      display_s1   <= '0;
      sample_valid <= 1'b0;
    end else begin
      lights_s1    <= {bus.column_traffic_lights, bus.row_traffic_lights};
      display_s1   <= {bus.column_display, bus.row_display};
      sample_valid <= 1'b1;
    end
  end

  for (genvar d = 0; d < 2; d++) begin : g_digits
    seven_segment_to_bcd u_tens (
      .pattern (display_s1[d][13:7]),
      .is_tens (1'b1),
      .digit   (tens_digit[d]),
      .valid   (tens_ok[d])
    );
    seven_segment_to_bcd u_ones (
      .pattern (display_s1[d][6:0]),
      .is_tens (1'b0),
      .digit   (ones_digit[d]),
      .valid   (ones_ok[d])
    );
    assign decoded[d] = 7'(tens_digit[d]) * 7'd10 + 7'(ones_digit[d]);
  end

  // Nothing is committed until stage 1 holds a real post-reset sample.
  always_comb begin
    flags       = '0;
    phase_d     = phase_q;
    count_d     = count_q;
    cycles_d    = cycles_q;
    value_d     = value_q;
    digit_err_d = digit_err_q;
    for (int d = 0; d < 2; d++) begin
      seen_phase[d] = light_to_phase(lights_s1[d]);
      changed[d]    = (seen_phase[d] != phase_q[d]);
      digit_bad[d]  = !(tens_ok[d] && ones_ok[d]);
      if (sample_valid) begin
        if (seen_phase[d] == PHASE_UNKNOWN)
          flags[ERR_ROW_CODE + d] = 1'b1;
        if (!legal_transition(phase_q[d], seen_phase[d]))
          flags[ERR_SEQUENCE] = 1'b1;
        if (digit_bad[d])
          flags[ERR_SEGMENT] = 1'b1;
        else
          value_d[d] = decoded[d];
        if (!changed[d] && seen_phase[d] != PHASE_UNKNOWN && !digit_bad[d] &&
            !digit_err_q[d] && decoded[d] != value_q[d] &&
            decoded[d] != value_q[d] - 7'd1)
          flags[ERR_COUNTDOWN] = 1'b1;
        // Durations adjacent to UNKNOWN are meaningless and not reported.
        if (changed[d]) begin
          count_d[d] = 8'd1;
          if (phase_q[d] != PHASE_UNKNOWN && seen_phase[d] != PHASE_UNKNOWN)
            cycles_d[d] = count_q[d];
        end else if (count_q[d] != 8'hFF) begin
          count_d[d] = count_q[d] + 8'd1;
        end
        phase_d[d]     = seen_phase[d];
        digit_err_d[d] = digit_bad[d];
      end
    end
    if (sample_valid && is_moving(seen_phase[0]) && is_moving(seen_phase[1]))
      flags[ERR_CONFLICT] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q[0]  <= PHASE_UNKNOWN;
      phase_q[1]  <= PHASE_UNKNOWN;
      count_q     <= '0;
      cycles_q    <= '0;
      value_q     <= '0;
      digit_err_q <= '0;
      error_q     <= '0;
    end else begin
      phase_q     <= phase_d;
      count_q     <= count_d;
      cycles_q    <= cycles_d;
      value_q     <= value_d;
      digit_err_q <= digit_err_d;
      error_q     <= error_q | flags;
    end
  end

  assign row_phase           = phase_q[0];
  assign column_phase        = phase_q[1];
  assign row_value           = value_q[0];
  assign column_value        = value_q[1];
  assign row_phase_cycles    = cycles_q[0];
  assign column_phase_cycles = cycles_q[1];
  assign error               = error_q;

endmodule
